aes_core_scheduler: RTL
=======================

# aes_core_scheduler

Sequencer and arbiter in front of the single `AES128` core. It accepts encrypt/decrypt jobs from two independent requesters, grants the core round-robin, and captures each job's message, key and direction. It then drives the core's `start`, waits the core's fixed latency, and returns the 128-bit result to the owning requester over a valid/ready handshake. It sits between the bus-side interface logic and `AES128` inside the chip top.

## Interface
Parameters:
- `LATENCY`, default 11: cycles from the `core_start` cycle to a stable `core_result`. Must be ≥1; any other value is an elaboration error.
- `NREQ`, fixed 2: number of requesters. Not user-overridable; taken from the package.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  [NREQ]  job offered. Once asserted, held until accepted.
- `req_ready`  out  [NREQ]  job accepted on a cycle where `req_valid[i] & req_ready[i]`.
- `req_msg`  in  [NREQ][128]  plaintext or ciphertext.
- `req_key`  in  [NREQ][128]  cipher key.
- `req_decrypt`  in  [NREQ]  1 = decrypt, 0 = encrypt.
- `rsp_valid`  out  [NREQ]  result available for requester i. One-hot or zero.
- `rsp_ready`  in  [NREQ]  requester i takes the result.
- `rsp_data`  out  128  result, shared by both requesters, qualified by `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `core_start`  out  1  one-cycle start pulse to `AES128.start`.
- `core_sel`  out  1  to `AES128.selCypher`, equals the captured `req_decrypt`.
- `core_msg`  out  128  to `AES128.message_in`, registered.
- `core_key`  out  128  to `AES128.key`, registered.
- `core_result`  in  128  from `AES128.message_out`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The arbiter picks a winner among the asserted `req_valid` bits. Only the winner's `req_ready` is high, combinationally.
  - On handshake: capture msg/key/decrypt into `core_*` registers, record the owner, go to ISSUE.
- ISSUE: `core_start`=1 for exactly this cycle. Load the counter with `LATENCY-1`, then go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At 0: register `core_result` into `rsp_data`, go to RESP.
- RESP:
  - `rsp_valid[owner]`=1; `rsp_data` is held stable.
  - On `rsp_ready[owner]`: go to IDLE and clear `rsp_valid`.
  - `rsp_ready` of the non-owner is ignored.
- Round-robin:
  - A pointer holds the last-granted index.
  - If both requesters are valid, the grant goes to the one not last granted.
  - After reset the pointer favours requester 0.
  - The pointer updates only on an accept.
- `core_msg`/`core_key`/`core_sel` hold the captured values from accept until the next accept. Requester inputs may change freely after their accept.
- Counter width: `$clog2(LATENCY+1)`. It must not wrap; the WAIT exit is on the value 0.
- Reset while `reset`=0, in any state:
  - State → IDLE; pointer, counter and owner → 0.
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_data`, `busy`, `core_start`, `core_sel`, `core_msg`, `core_key`.
  - Any in-flight job is dropped with no response.

## Timing
- Cycle A: accept. Cycle A+1: ISSUE (`core_start`=1). Cycles A+2 … A+LATENCY: WAIT. The result is sampled on the edge ending cycle A+LATENCY. `rsp_valid` is high from cycle A+LATENCY+1.
- Minimum accept-to-`rsp_valid`: LATENCY+1 cycles. If `rsp_ready` is already high, it returns to IDLE at A+LATENCY+2. The next accept is possible in cycle A+LATENCY+2.
- `req_ready` is never high outside IDLE. A request arriving during a job waits with no loss.
- A request that is valid in the same cycle the FSM returns to IDLE is arbitrated in that cycle.
- `busy` is registered and follows the state with no lag.

## Structure
- Package `aes_ctrl_pkg`:
  - `AES_W`=128, `NREQ`=2.
  - `typedef enum logic[1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t`.
  - `typedef logic[AES_W-1:0] aes_block_t`.
- Sub-module `rr_arbiter`:
  - Ports: `req[NREQ]`, `last`, `grant[NREQ]` (one-hot, combinational), `grant_idx`.
  - Pointer register stays in the scheduler.
- Top-level integration instantiates `AES128` with `core_*` connected one-to-one.

## Test plan
- Single job: requester 0, msg 0x00112233445566778899aabbccddeeff, key 0x000102…0f, encrypt. Expect `core_start` pulse at A+1 and `rsp_valid[0]` at A+12. `rsp_data` must equal the FIPS-197 vector 0x69c4e0d86a7b0430d8cdb78070b4c55a.
- Decrypt round-trip: feed that ciphertext with `req_decrypt`=1. Expect the original plaintext and `core_sel`=1 throughout.
- Contention: both requesters valid continuously for 4 jobs. Grants must alternate 0,1,0,1 and exactly one `req_ready` is high per accept.
- Backpressure: hold `rsp_ready[1]`=0 for 20 cycles. `rsp_valid[1]` and `rsp_data` stay stable, `req_ready` stays 0, and requester 0's pending job is accepted only after the response completes.
- Reset mid-WAIT: deassert `reset` at A+5. All outputs go to 0 immediately (async). After release the FSM is in IDLE, no `rsp_valid` appears for the dropped job, and the first grant goes to requester 0.
- Non-owner ready: pulse `rsp_ready[0]` while RESP is for requester 1. There must be no state change.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared widths, FSM encoding and block type for the AES core scheduler.
package aes_ctrl_pkg;

    localparam int AES_W = 128;
    localparam int NREQ  = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;

    typedef logic [AES_W-1:0] aes_block_t;

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin arbiter: on contention the requester that was not
// granted last wins. The priority pointer itself lives in the caller.
module rr_arbiter
    import aes_ctrl_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last,
    output logic [NREQ-1:0] grant,
    output logic            grant_idx
);

    always_comb begin
        grant_idx = 1'b0;
        if (req[0] && req[1]) begin
            grant_idx = ~last;
        end else if (req[1]) begin
            grant_idx = 1'b1;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
        assign grant[gi] = (|req) && (grant_idx == 1'(gi));
    end

endmodule

// File: rtl/aes_core_scheduler.sv
// Arbitrates two requesters onto one fixed-latency AES128 core and returns
// each result to its owner over a valid/ready handshake.
module aes_core_scheduler
    import aes_ctrl_pkg::*;
#(
    parameter int LATENCY = 11
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][AES_W-1:0] req_msg,
    input  logic [NREQ-1:0][AES_W-1:0] req_key,
    input  logic [NREQ-1:0]            req_decrypt,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output aes_block_t                 rsp_data,
    output logic                       busy,
    output logic                       core_start,
    output logic                       core_sel,
    output aes_block_t                 core_msg,
    output aes_block_t                 core_key,
    input  aes_block_t                 core_result
);

    if (LATENCY < 1) begin : g_bad_latency
        $error("aes_core_scheduler: LATENCY must be at least 1");
    end

    localparam int CNT_W = $clog2(LATENCY + 1);

    sched_state_t     state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             owner_reg;
    // Holds the requester favoured on the next contention; equivalent to the
    // inverse of the last-granted index, so reset to 0 favours requester 0.
    logic             prio_reg;

    logic [NREQ-1:0]  grant;
    logic             grant_idx;
    logic [NREQ-1:0]  owner_onehot;
    logic             accept;

    rr_arbiter u_arb (
        .req       (req_valid),
        .last      (~prio_reg),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner
        assign owner_onehot[gi] = (owner_reg == 1'(gi));
    end

    // Gated by reset as well so req_ready is 0 while reset is held.
    assign req_ready = (reset && state_reg == IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            owner_reg  <= 1'b0;
            prio_reg   <= 1'b0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            busy       <= 1'b0;
            core_start <= 1'b0;
            core_sel   <= 1'b0;
            core_msg   <= '0;
            core_key   <= '0;
        end else begin
            core_start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        core_msg   <= req_msg[grant_idx];
                        core_key   <= req_key[grant_idx];
                        core_sel   <= req_decrypt[grant_idx];
                        owner_reg  <= grant_idx;
                        prio_reg   <= ~grant_idx;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // With a single-cycle core the result is already stable here.
                    if (LATENCY == 1) begin
                        rsp_data  <= core_result;
                        rsp_valid <= owner_onehot;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg   <= CNT_W'(LATENCY - 1);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    // Leave on the edge that takes the counter to 0.
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        rsp_data  <= core_result;
                        rsp_valid <= owner_onehot;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
